// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle player engine.
package tron_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    // Player word layout: [17:16] dir, [15] alive, [14:7] x, [6:0] y
    localparam int PW_W         = 18;
    localparam int PW_DIR_LSB   = 16;
    localparam int PW_ALIVE_BIT = 15;
    localparam int PW_X_LSB     = 7;
    localparam int PW_Y_LSB     = 0;

    typedef struct packed {
        logic [1:0] dir;
        logic       alive;
        logic [7:0] x;
        logic [6:0] y;
    } pword_t;

    localparam logic [7:0] X_MAX_DEF = 8'd159;
    localparam logic [6:0] Y_MAX_DEF = 7'd119;

    // Start cells packed as {x[7:0], y[6:0], dir[1:0]}
    localparam logic [16:0] START_P1_DEF = {8'd150, 7'd110, RIGHT ^ RIGHT};
    localparam logic [16:0] START_P2_DEF = {8'd10,  7'd10,  DOWN};
    localparam logic [16:0] START_P3_DEF = {8'd150, 7'd10,  LEFT};
    localparam logic [16:0] START_P4_DEF = {8'd10,  7'd110, RIGHT};

    typedef enum logic [2:0] {
        S_CLEAR, S_SEED, S_IDLE, S_CALC, S_READ, S_CHECK, S_NEXT, S_OVER
    } state_e;

    // Expand a packed start constant into a live player word
    function automatic pword_t start_word(input logic [16:0] s);
        pword_t w;
        w.dir   = s[1:0];
        w.alive = 1'b1;
        w.x     = s[16:9];
        w.y     = s[8:2];
        return w;
    endfunction

endpackage

// File: rtl/occupancy_ram.sv
// 1-bit trail occupancy store: single port, synchronous write, registered read.
module occupancy_ram #(
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);
    logic mem_q [0:(1<<AW)-1];

    // Read-first port: rdata shows the cell contents before any same-cycle write
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/tron_player_engine.sv
// Advances four light-cycles one pixel per game tick, resolving wall and
// trail collisions against the occupancy RAM, and tracks the game result.
module tron_player_engine
    import tron_pkg::*;
#(
    parameter logic [7:0]  X_MAX    = X_MAX_DEF,
    parameter logic [6:0]  Y_MAX    = Y_MAX_DEF,
    parameter logic [16:0] START_P1 = START_P1_DEF,
    parameter logic [16:0] START_P2 = START_P2_DEF,
    parameter logic [16:0] START_P3 = START_P3_DEF,
    parameter logic [16:0] START_P4 = START_P4_DEF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick,
    input  logic [4:0]  KEY_PRESSED,
    output logic [17:0] p1,
    output logic [17:0] p2,
    output logic [17:0] p3,
    output logic [17:0] p4,
    output logic        busy,
    output logic        game_over,
    output logic [2:0]  winner,
    output logic        overrun
);
    state_e          state_q, state_d;
    logic [14:0]     clr_cnt_q;
    logic [1:0]      idx_q;
    pword_t [3:0]    pw_q;
    logic [3:0][1:0] pend_q;
    logic [7:0]      tgt_x_q;
    logic [6:0]      tgt_y_q;
    logic            game_over_q;
    logic [2:0]      winner_q;
    logic            overrun_q;

    logic [3:0][16:0] start_cfg;
    pword_t           cur;
    pword_t           seed;
    logic             wall;
    logic [7:0]       nx;
    logic [6:0]       ny;
    logic [2:0]       alive_cnt;
    logic [2:0]       last_alive;
    logic             ram_we;
    logic             ram_wdata;
    logic [14:0]      ram_addr;
    logic             ram_rdata;
    logic [1:0]       key_pl;
    logic [1:0]       key_dir;

    assign start_cfg = {START_P4, START_P3, START_P2, START_P1};
    assign cur       = pw_q[idx_q];
    assign seed      = start_word(start_cfg[idx_q]);
    assign key_pl    = KEY_PRESSED[3:2];
    assign key_dir   = KEY_PRESSED[1:0];

    assign p1        = pw_q[0];
    assign p2        = pw_q[1];
    assign p3        = pw_q[2];
    assign p4        = pw_q[3];
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign overrun   = overrun_q;

    occupancy_ram #(.AW(15)) u_ram (
        .clk_i   (CLOCK_50),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Next cell for the player under evaluation; wall flags a move off the field
    always_comb begin
        nx   = cur.x;
        ny   = cur.y;
        wall = 1'b0;
        case (cur.dir)
            UP:      if (cur.y == 7'd0)  wall = 1'b1; else ny = cur.y - 7'd1;
            RIGHT:   if (cur.x == X_MAX) wall = 1'b1; else nx = cur.x + 8'd1;
            DOWN:    if (cur.y == Y_MAX) wall = 1'b1; else ny = cur.y + 7'd1;
            default: if (cur.x == 8'd0)  wall = 1'b1; else nx = cur.x - 8'd1;
        endcase
    end

    // Survivor count and the highest-numbered survivor (the only one when count is 1)
    always_comb begin
        alive_cnt  = 3'd0;
        last_alive = 3'd0;
        for (int j = 0; j < 4; j++) begin
            if (pw_q[j].alive) begin
                alive_cnt  = alive_cnt + 3'd1;
                last_alive = 3'(j + 1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_cnt_q == 15'h7FFF) state_d = S_SEED;
            S_SEED:  if (idx_q == 2'd3) state_d = S_IDLE;
            S_IDLE:  if (tick && !game_over_q) state_d = S_CALC;
            S_CALC:  state_d = (!cur.alive || wall) ? S_NEXT : S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = S_NEXT;
            S_NEXT: begin
                if (idx_q != 2'd3)        state_d = S_CALC;
                else if (alive_cnt <= 3'd1) state_d = S_OVER;
                else                      state_d = S_IDLE;
            end
            default: state_d = S_OVER;
        endcase
    end

    // FSM outputs: busy flag and occupancy RAM port control
    always_comb begin
        busy      = !(state_q == S_IDLE || state_q == S_OVER);
        ram_we    = 1'b0;
        ram_wdata = 1'b0;
        ram_addr  = {tgt_x_q, tgt_y_q};
        case (state_q)
            S_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q;
            end
            S_SEED: begin
                ram_we    = 1'b1;
                ram_wdata = 1'b1;
                ram_addr  = {seed.x, seed.y};
            end
            S_CALC:  ram_addr = {nx, ny};
            S_CHECK: begin
                ram_we    = !ram_rdata;
                ram_wdata = 1'b1;
            end
            default: ;
        endcase
    end

    // Player words, pending directions, step bookkeeping and status flags
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int j = 0; j < 4; j++) begin
                pw_q[j]   <= start_word(start_cfg[j]);
                pend_q[j] <= start_cfg[j][1:0];
            end
            clr_cnt_q   <= '0;
            idx_q       <= '0;
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            if (tick && busy) overrun_q <= 1'b1;

            // Reversals are judged against the heading actually in use
            if (KEY_PRESSED[4] && pw_q[key_pl].alive &&
                key_dir != (pw_q[key_pl].dir ^ 2'b10))
                pend_q[key_pl] <= key_dir;

            case (state_q)
                S_CLEAR: clr_cnt_q <= clr_cnt_q + 15'd1;
                S_SEED:  idx_q <= idx_q + 2'd1;
                S_IDLE: begin
                    if (tick && !game_over_q) begin
                        for (int j = 0; j < 4; j++) pw_q[j].dir <= pend_q[j];
                        idx_q <= 2'd0;
                    end
                end
                S_CALC: begin
                    if (cur.alive) begin
                        if (wall) pw_q[idx_q].alive <= 1'b0;
                        tgt_x_q <= nx;
                        tgt_y_q <= ny;
                    end
                end
                S_CHECK: begin
                    if (ram_rdata) begin
                        pw_q[idx_q].alive <= 1'b0;
                    end else begin
                        pw_q[idx_q].x <= tgt_x_q;
                        pw_q[idx_q].y <= tgt_y_q;
                    end
                end
                S_NEXT: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3 && alive_cnt <= 3'd1) begin
                        game_over_q <= 1'b1;
                        winner_q    <= (alive_cnt == 3'd1) ? last_alive : 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tron_player_engine.sv
// Scoreboard bench: a behavioural game model predicts each tick's outcome.
module tb_tron_player_engine;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [4:0]  KEY_PRESSED = 5'd0;
    logic [17:0] p1, p2, p3, p4;
    logic        busy, game_over, overrun;
    logic [2:0]  winner;

    tron_player_engine dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .tick        (tick),
        .KEY_PRESSED (KEY_PRESSED),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .busy        (busy),
        .game_over   (game_over),
        .winner      (winner),
        .overrun     (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [3:0][17:0] p;
        logic             over;
        logic [2:0]       win;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    int mx[4], my[4], md[4], mpend[4];
    bit ma[4];
    bit occ[0:32767];
    bit mover;
    int mwin;

    localparam logic [17:0] S1 = {2'd0, 1'b1, 8'd150, 7'd110};
    localparam logic [17:0] S2 = {2'd2, 1'b1, 8'd10,  7'd10};
    localparam logic [17:0] S3 = {2'd3, 1'b1, 8'd150, 7'd10};
    localparam logic [17:0] S4 = {2'd1, 1'b1, 8'd10,  7'd110};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [17:0] mword(input int i);
        return {2'(md[i]), ma[i], 8'(mx[i]), 7'(my[i])};
    endfunction

    task automatic model_reset();
        mx = '{150, 10, 150, 10};
        my = '{110, 10, 10, 110};
        md = '{0, 2, 3, 1};
        mpend = md;
        ma = '{1, 1, 1, 1};
        for (int a = 0; a < 32768; a++) occ[a] = 1'b0;
        for (int i = 0; i < 4; i++) occ[mx[i] * 128 + my[i]] = 1'b1;
        mover = 1'b0;
        mwin = 0;
    endtask

    task automatic model_tick(output exp_t e);
        int nx, ny, cnt, last;
        bit wall;
        e.cyc = 0;
        if (!mover) begin
            for (int i = 0; i < 4; i++) md[i] = mpend[i];
            for (int i = 0; i < 4; i++) begin
                if (!ma[i]) begin
                    e.cyc += 2;
                end else begin
                    nx = mx[i]; ny = my[i]; wall = 1'b0;
                    case (md[i])
                        0: if (my[i] == 0)   wall = 1'b1; else ny = my[i] - 1;
                        1: if (mx[i] == 159) wall = 1'b1; else nx = mx[i] + 1;
                        2: if (my[i] == 119) wall = 1'b1; else ny = my[i] + 1;
                        default: if (mx[i] == 0) wall = 1'b1; else nx = mx[i] - 1;
                    endcase
                    if (wall) begin
                        ma[i] = 1'b0;
                        e.cyc += 2;
                    end else begin
                        e.cyc += 4;
                        if (occ[nx * 128 + ny]) ma[i] = 1'b0;
                        else begin
                            occ[nx * 128 + ny] = 1'b1;
                            mx[i] = nx; my[i] = ny;
                        end
                    end
                end
            end
            cnt = 0; last = 0;
            for (int i = 0; i < 4; i++) if (ma[i]) begin cnt++; last = i + 1; end
            if (cnt <= 1) begin
                mover = 1'b1;
                mwin = (cnt == 1) ? last : 0;
            end
        end
        for (int i = 0; i < 4; i++) e.p[i] = mword(i);
        e.over = mover;
        e.win = 3'(mwin);
    endtask

    task automatic press(input int pl, input int d);
        if (ma[pl] && d != (md[pl] ^ 2)) mpend[pl] = d;
        @(negedge CLOCK_50) KEY_PRESSED = {1'b1, 2'(pl), 2'(d)};
        @(posedge CLOCK_50); #1 KEY_PRESSED = 5'd0;
    endtask

    task automatic compare_out(input exp_t e, input int cyc, input bit check_cyc);
        chk("p1", 32'(p1), 32'(e.p[0]));
        chk("p2", 32'(p2), 32'(e.p[1]));
        chk("p3", 32'(p3), 32'(e.p[2]));
        chk("p4", 32'(p4), 32'(e.p[3]));
        chk("game_over", 32'(game_over), 32'(e.over));
        chk("winner", 32'(winner), 32'(e.win));
        if (check_cyc) chk("busy_cycles", cyc, e.cyc);
    endtask

    // Pulse tick, count busy cycles, then score the result.
    // With extra set, a second tick is pulsed mid-step and must not be queued.
    task automatic do_tick(input bit extra);
        exp_t e, got;
        int cyc;
        model_tick(e);
        sb.push_back(e);
        @(negedge CLOCK_50) tick = 1'b1;
        @(posedge CLOCK_50); #1 tick = 1'b0;
        cyc = 0;
        while (busy && cyc < 64) begin
            cyc++;
            if (extra && cyc == 3) begin
                @(negedge CLOCK_50) tick = 1'b1;
                @(posedge CLOCK_50); #1 tick = 1'b0;
            end else begin
                @(posedge CLOCK_50); #1;
            end
        end
        if (busy) chk("step_timeout", 32'(busy), 32'd0);
        if (extra) begin
            chk("overrun_set", 32'(overrun), 32'd1);
            repeat (3) @(posedge CLOCK_50);
            #1 chk("extra_tick_dropped", 32'(busy), 32'd0);
        end
        got = sb.pop_front();
        compare_out(got, cyc, !extra);
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        do begin
            @(posedge CLOCK_50); #1;
            cnt++;
        end while (busy && cnt < 40000);
        chk("clear_cycles", cnt, 32772);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge CLOCK_50) reset = 1'b0;
        wait_clear();
        chk("start_p1", 32'(p1), 32'(S1));
        chk("start_p2", 32'(p2), 32'(S2));
        chk("start_p3", 32'(p3), 32'(S3));
        chk("start_p4", 32'(p4), 32'(S4));

        // Plain step
        do_tick(1'b0);
        chk("p1_y_step", 32'(p1[6:0]), 32'd109);
        chk("p3_x_step", 32'(p3[14:7]), 32'd149);

        // Turn right, then a rejected reversal
        press(0, 1);
        do_tick(1'b0);
        chk("p1_right", 32'(p1), {14'd0, 2'd1, 1'b1, 8'd151, 7'd109});
        press(0, 3);
        do_tick(1'b0);
        chk("p1_no_reverse", 32'(p1[14:7]), 32'd152);

        // Tick while busy
        do_tick(1'b1);

        // Reset in the middle of a step
        @(negedge CLOCK_50) tick = 1'b1;
        @(posedge CLOCK_50); #1 tick = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50) reset = 1'b1;
        @(posedge CLOCK_50); #1;
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_p1", 32'(p1), 32'(S1));
        chk("midrst_p2", 32'(p2), 32'(S2));
        chk("midrst_p3", 32'(p3), 32'(S3));
        chk("midrst_p4", 32'(p4), 32'(S4));
        model_reset();
        @(negedge CLOCK_50) reset = 1'b0;
        wait_clear();

        // p4 heads for the bottom wall; p2 turns and runs into the top wall
        press(3, 2);
        press(1, 1);
        do_tick(1'b0);
        press(1, 0);
        for (int t = 0; t < 11; t++) do_tick(1'b0);
        chk("p2_wall", 32'(p2), {14'd0, 2'd0, 1'b0, 8'd11, 7'd0});
        chk("p4_dead", 32'(p4[15]), 32'd0);
        chk("p1_alive", 32'(p1[15]), 32'd1);

        // Keys to a dead player are ignored
        press(1, 1);
        do_tick(1'b0);

        // p1 loops back into its own trail
        press(0, 1);
        do_tick(1'b0);
        press(0, 2);
        do_tick(1'b0);
        press(0, 3);
        do_tick(1'b0);
        if (!mover) begin
            press(0, 0);
            do_tick(1'b0);
        end
        chk("final_over", 32'(game_over), 32'd1);
        chk("final_winner", 32'(winner), 32'd3);
        chk("final_p1_dead", 32'(p1[15]), 32'd0);

        // Ticks after game over change nothing
        do_tick(1'b0);
        do_tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
